// File: rtl/vga_stream_sink.sv
// VGA output stage: 640x480@60 timing from a divide-by-2 pixel enable, fed by a
// valid/ready RGB stream that realigns to frame boundaries on a start-of-frame marker.
module vga_stream_sink #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pix_valid,
    input  logic       pix_sof,
    input  logic [2:0] pix_rgb,
    output logic       pix_ready,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b,
    output logic       underflow
);

    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    typedef enum logic [1:0] {SEEK, WAIT_FRAME, STREAM} state_t;

    state_t     state_q, state_d;
    logic       tick_q;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [2:0] rgb_q, rgb_d;
    logic       underflow_q, underflow_d;
    logic       visible;
    logic       origin;
    logic       slot_live;

    assign visible = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    assign origin  = (hcnt_q == '0) && (vcnt_q == '0);

    // slot_live marks a pixel slot that belongs to the stream (including the resync slot at 0,0)
    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        slot_live = 1'b0;
        case (state_q)
            SEEK: begin
                if (pix_valid && pix_sof) state_d = WAIT_FRAME;
                else                      pix_ready = 1'b1;
            end
            WAIT_FRAME: begin
                if (tick_q && origin) begin
                    state_d   = STREAM;
                    slot_live = 1'b1;
                    pix_ready = 1'b1;
                end
            end
            STREAM: begin
                if (tick_q && visible) begin
                    slot_live = 1'b1;
                    if (pix_valid && pix_sof && !origin) state_d = WAIT_FRAME;
                    else                                 pix_ready = 1'b1;
                end
            end
            default: state_d = SEEK;
        endcase
        if (!reset) pix_ready = 1'b0;
    end

    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        rgb_d       = rgb_q;
        underflow_d = 1'b0;
        if (tick_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
            hsync_d     = !((hcnt_q >= H_SS) && (hcnt_q < H_SE));
            vsync_d     = !((vcnt_q >= V_SS) && (vcnt_q < V_SE));
            rgb_d       = (slot_live && pix_ready && pix_valid) ? pix_rgb : '0;
            underflow_d = slot_live && !pix_valid;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= SEEK;
            tick_q      <= 1'b0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= ~tick_q;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end
    end

    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign vga_r     = rgb_q[2];
    assign vga_g     = rgb_q[1];
    assign vga_b     = rgb_q[0];
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_stream_sink.sv
// Bench for vga_stream_sink: a reduced-geometry instance driven by a randomized upstream
// and checked every cycle against a position-arithmetic model, plus a default-geometry instance.
module tb_vga_stream_sink;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3, HT = HV + HF + HS + HB;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT * 2;
    localparam int DHT = 800, DVT = 525;
    localparam int M_SEEK = 0, M_WAIT = 1, M_STREAM = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pix_valid = 1'b0;
    logic       pix_sof = 1'b0;
    logic [2:0] pix_rgb = 3'b000;
    logic       pix_ready, vga_hsync, vga_vsync, vga_r, vga_g, vga_b, underflow;
    logic       d_ready, d_hs, d_vs, d_r, d_g, d_b, d_uf;

    vga_stream_sink #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clock(clock), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_rgb(pix_rgb), .pix_ready(pix_ready), .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .underflow(underflow)
    );

    vga_stream_sink dut_def (
        .clock(clock), .reset(reset), .pix_valid(1'b0), .pix_sof(1'b0),
        .pix_rgb(3'b000), .pix_ready(d_ready), .vga_hsync(d_hs), .vga_vsync(d_vs),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .underflow(d_uf)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // model: clocks since reset release, stream mode, expected registered outputs
    int         cyc;
    int         mode;
    logic       exp_hs, exp_vs, exp_uf, dexp_hs, dexp_vs;
    logic [2:0] exp_rgb;

    // upstream source and observation counters
    bit         src_en, gap_en, mis_en, mis_done, sof_req;
    int         pre_n;
    logic [2:0] mis_rgb;
    int         hs_cnt, uf_cnt, blank_hs;

    function automatic int hpos(int c);
        return (c / 2) % HT;
    endfunction

    function automatic int vpos(int c);
        return ((c / 2) / HT) % VT;
    endfunction

    task automatic model_reset();
        cyc = 0; mode = M_SEEK;
        exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 3'b000; exp_uf = 1'b0;
        dexp_hs = 1'b1; dexp_vs = 1'b1;
    endtask

    task automatic gen_pixel();
        int h = hpos(cyc);
        int v = vpos(cyc);
        pix_rgb = 3'($urandom_range(0, 7));
        pix_sof = 1'b0;
        if (pre_n > 0) begin
            pre_n--;
        end else if (sof_req) begin
            pix_sof = 1'b1; pix_rgb = 3'b100; sof_req = 1'b0;
        end else if (mis_en && !mis_done && h == 8 && v == 4) begin
            pix_sof = 1'b1; pix_rgb = 3'($urandom_range(1, 7));
            mis_rgb = pix_rgb; mis_done = 1'b1;
        end
    endtask

    task automatic drive_valid();
        int h = hpos(cyc);
        int v = vpos(cyc);
        pix_valid = src_en && !(gap_en && v == 3 && h >= 5 && h <= 9);
    endtask

    // One clock: check this cycle at the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit tick, vis, org, rdy, hs, live;
        int p, h, v, dh, dv;
        @(negedge clock);
        tick = (cyc % 2) == 1;
        p = cyc / 2; h = p % HT; v = (p / HT) % VT;
        vis = (h < HV) && (v < VV);
        org = (h == 0) && (v == 0);
        case (mode)
            M_SEEK:  rdy = !(pix_valid && pix_sof);
            M_WAIT:  rdy = tick && org;
            default: rdy = tick && vis && !(pix_valid && pix_sof && !org);
        endcase
        live = (mode == M_STREAM && tick && vis) || (mode == M_WAIT && tick && org);
        checks++;
        if (pix_ready !== rdy) begin
            errors++; $display("FAIL ready cyc=%0d (%0d,%0d) got %b want %b", cyc, h, v, pix_ready, rdy);
        end
        checks++;
        if ({vga_hsync, vga_vsync, vga_r, vga_g, vga_b, underflow} !== {exp_hs, exp_vs, exp_rgb, exp_uf}) begin
            errors++;
            $display("FAIL outputs cyc=%0d got hs/vs/rgb/uf=%b%b_%b%b%b_%b want %b%b_%b_%b",
                     cyc, vga_hsync, vga_vsync, vga_r, vga_g, vga_b, underflow, exp_hs, exp_vs, exp_rgb, exp_uf);
        end
        checks++;
        if ({d_ready, d_hs, d_vs, d_r, d_g, d_b, d_uf} !== {1'b1, dexp_hs, dexp_vs, 4'b0000}) begin
            errors++;
            $display("FAIL default_geom cyc=%0d got rdy/hs/vs/rgb/uf=%b%b%b%b%b%b%b want 1%b%b0000",
                     cyc, d_ready, d_hs, d_vs, d_r, d_g, d_b, d_uf, dexp_hs, dexp_vs);
        end
        if (pix_ready && pix_valid) begin
            hs_cnt++;
            if (mode == M_STREAM && !vis) blank_hs++;
        end
        if (underflow) uf_cnt++;
        hs = rdy && pix_valid;
        exp_uf = 1'b0;
        if (tick) begin
            exp_hs  = !(h >= HV + HF && h < HV + HF + HS);
            exp_vs  = !(v >= VV + VF && v < VV + VF + VS);
            exp_rgb = (live && hs) ? pix_rgb : 3'b000;
            exp_uf  = live && !pix_valid;
            dh = p % DHT; dv = (p / DHT) % DVT;
            dexp_hs = !(dh >= 656 && dh < 752);
            dexp_vs = !(dv >= 490 && dv < 492);
        end
        case (mode)
            M_SEEK:  if (pix_valid && pix_sof) mode = M_WAIT;
            M_WAIT:  if (tick && org) mode = M_STREAM;
            default: if (tick && vis && pix_valid && pix_sof && !org) mode = M_WAIT;
        endcase
        @(posedge clock); #1;
        cyc++;
        if (hs && src_en) gen_pixel();
        drive_valid();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        src_en = 1'b0; gap_en = 1'b0; mis_en = 1'b0; sof_req = 1'b0; pre_n = 0;
        pix_valid = 1'b0; pix_sof = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        pix_valid = 1'b1; pix_sof = 1'b0;
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({vga_hsync, vga_vsync, vga_r, vga_g, vga_b, underflow, pix_ready} !== 7'b1100000) begin
            errors++; $display("FAIL reset_async got %b want 1100000",
                               {vga_hsync, vga_vsync, vga_r, vga_g, vga_b, underflow, pix_ready});
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({d_hs, d_vs, d_r, d_g, d_b, d_uf, d_ready} !== 7'b1100000) begin
            errors++; $display("FAIL reset_default got %b want 1100000", {d_hs, d_vs, d_r, d_g, d_b, d_uf, d_ready});
        end
        apply_reset();
    endtask

    task automatic test_idle();
        int hlow = 0;
        int vlow = 0;
        uf_cnt = 0;
        repeat (FRAME) step();
        repeat (FRAME) begin
            step();
            if (!vga_hsync) hlow++;
            if (!vga_vsync) vlow++;
        end
        checks++;
        if (hlow != HS * VT * 2) begin errors++; $display("FAIL idle_hsync_low got %0d want %0d", hlow, HS * VT * 2); end
        checks++;
        if (vlow != VS * HT * 2) begin errors++; $display("FAIL idle_vsync_low got %0d want %0d", vlow, VS * HT * 2); end
        checks++;
        if (uf_cnt != 0) begin errors++; $display("FAIL idle_underflow got %0d want 0", uf_cnt); end
    endtask

    task automatic test_stream();
        int n = 0;
        src_en = 1'b1; sof_req = 1'b1;
        gen_pixel(); drive_valid();
        while (mode != M_STREAM && n < 3 * FRAME) begin step(); n++; end
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b100) begin
            errors++; $display("FAIL stream_first_pixel got %b want 100 (after %0d clocks)", {vga_r, vga_g, vga_b}, n);
        end
        hs_cnt = 0; blank_hs = 0;
        repeat (FRAME) step();
        checks++;
        if (hs_cnt != HV * VV) begin errors++; $display("FAIL stream_handshakes got %0d want %0d", hs_cnt, HV * VV); end
        checks++;
        if (blank_hs != 0) begin errors++; $display("FAIL stream_blank_handshakes got %0d want 0", blank_hs); end
    endtask

    task automatic test_underflow();
        gap_en = 1'b1; uf_cnt = 0;
        repeat (FRAME) step();
        gap_en = 1'b0;
        checks++;
        if (uf_cnt != 5) begin errors++; $display("FAIL underflow_pulses got %0d want 5", uf_cnt); end
    endtask

    task automatic test_seek_discard();
        int n = 0;
        apply_reset();
        src_en = 1'b1; pre_n = 7; sof_req = 1'b1; hs_cnt = 0;
        gen_pixel(); drive_valid();
        while (mode == M_SEEK && n < 100) begin step(); n++; end
        checks++;
        if (hs_cnt != 7) begin errors++; $display("FAIL seek_discards got %0d want 7", hs_cnt); end
        while (mode != M_STREAM && n < 3 * FRAME) begin step(); n++; end
        checks++;
        if (hs_cnt != 8) begin errors++; $display("FAIL seek_sof_accept got %0d handshakes want 8", hs_cnt); end
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b100) begin
            errors++; $display("FAIL seek_first_pixel got %b want 100", {vga_r, vga_g, vga_b});
        end
        repeat (FRAME / 2) step();
    endtask

    task automatic test_misaligned_sof();
        int n = 0;
        mis_en = 1'b1; mis_done = 1'b0;
        while (mode != M_WAIT && n < 3 * FRAME) begin step(); n++; end
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b000) begin
            errors++; $display("FAIL mis_black got %b want 000", {vga_r, vga_g, vga_b});
        end
        hs_cnt = 0;
        while (mode != M_STREAM && n < 6 * FRAME) begin step(); n++; end
        checks++;
        if (hs_cnt != 1) begin errors++; $display("FAIL mis_wait_handshakes got %0d want 1", hs_cnt); end
        checks++;
        if ({vga_r, vga_g, vga_b} !== mis_rgb) begin
            errors++; $display("FAIL mis_resync_pixel got %b want %b", {vga_r, vga_g, vga_b}, mis_rgb);
        end
        mis_en = 1'b0;
        repeat (FRAME / 2) step();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (!(hpos(cyc) == 10 && vpos(cyc) == 5) && n < 2 * FRAME) begin step(); n++; end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({vga_hsync, vga_vsync, vga_r, vga_g, vga_b, underflow, pix_ready} !== 7'b1100000) begin
            errors++; $display("FAIL midreset_async got %b want 1100000",
                               {vga_hsync, vga_vsync, vga_r, vga_g, vga_b, underflow, pix_ready});
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({vga_hsync, vga_vsync, vga_r, vga_g, vga_b, underflow, pix_ready} !== 7'b1100000) begin
            errors++; $display("FAIL midreset_held got %b want 1100000",
                               {vga_hsync, vga_vsync, vga_r, vga_g, vga_b, underflow, pix_ready});
        end
        reset = 1'b1;
        model_reset();
        sof_req = 1'b1;
        n = 0;
        while (mode != M_STREAM && n < 3 * FRAME) begin step(); n++; end
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b100) begin
            errors++; $display("FAIL midreset_resync got %b want 100", {vga_r, vga_g, vga_b});
        end
        repeat (FRAME) step();
    endtask

    initial begin
        model_reset();
        src_en = 1'b0; gap_en = 1'b0; mis_en = 1'b0; mis_done = 1'b0; sof_req = 1'b0;
        pre_n = 0; hs_cnt = 0; uf_cnt = 0; blank_hs = 0; mis_rgb = 3'b000;
        test_reset();
        test_idle();
        test_stream();
        test_underflow();
        test_seek_discard();
        test_misaligned_sof();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_stream_sink.md
Name: vga_stream_sink

Overview:
- Final VGA output stage of the image viewer.
- Consumes a 3-bit RGB pixel stream from an upstream image source over a valid/ready handshake.
- Generates 640x480@60 timing from the 50 MHz system clock using an internal divide-by-2 pixel enable.
- Drives the 1-bit-per-colour VGA pins and realigns to frame boundaries using a start-of-frame marker.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clock  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset
pix_valid  input  1  upstream pixel valid
pix_sof  input  1  qualifies pixel as first of frame, (0,0)
pix_rgb  input  3  {r,g,b} pixel data
pix_ready  output  1  sink accepts pixel this cycle
vga_hsync  output  1  horizontal sync, active-low
vga_vsync  output  1  vertical sync, active-low
vga_r  output  1  red
vga_g  output  1  green
vga_b  output  1  blue
underflow  output  1  one-cycle pulse: visible pixel slot with no valid pixel

Behaviour:
- Reset (reset=0, asynchronous):
  - tick=0, hcnt=0, vcnt=0, state=SEEK.
  - vga_hsync=1, vga_vsync=1, vga_r/g/b=0, underflow=0.
  - pix_ready is combinational and evaluates to 0 while in reset.
- tick toggles every clock, so it is high on every second clock. hcnt/vcnt advance only on tick.
- hcnt counts 0..H_TOTAL-1 (800) and wraps to 0. On that wrap, vcnt increments 0..V_TOTAL-1 (525) and wraps to 0.
- Counter widths: 10 bits each.
- visible = hcnt<H_VISIBLE && vcnt<V_VISIBLE.
- hs_n is low for hcnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. 656..751.
- vs_n is low for vcnt in [490, 492).
- All VGA outputs are registered, updated on tick. Syncs and colour for counter position (h,v) appear together one clock after the tick cycle at (h,v).
- Colour is 0 whenever !visible or state!=STREAM.
- State machine:
  - SEEK: pix_ready=1 every cycle; pixels with pix_sof=0 are discarded. A handshake with pix_valid&&pix_sof is not consumed: pix_ready is 0 when pix_valid&&pix_sof, and the state moves to WAIT_FRAME.
  - WAIT_FRAME: pix_ready=0. Upstream holds the sof pixel. On the tick cycle with hcnt=0 and vcnt=0, transition to STREAM, and the same tick consumes the pixel (see STREAM).
  - STREAM: pix_ready = tick && visible. When pix_ready && pix_valid, the pixel is latched to the colour outputs.
- Underflow: in STREAM, on tick && visible && !pix_valid:
  - output black for that slot;
  - underflow=1 for exactly one clock;
  - remain in STREAM.
- Misaligned sof: in STREAM, a handshake with pix_sof=1 at any position other than (0,0) is treated as follows:
  - the pixel is not consumed (pix_ready forced 0 for it);
  - the slot displays black;
  - state moves to WAIT_FRAME.
- pix_sof=0 at (0,0) in STREAM is accepted normally, with no resync.
- Timing counters never stop or reset except on reset. Sync output is independent of stream state.
- Reset asserted mid-frame:
  - all outputs go to reset values immediately;
  - after release, resume in SEEK with hcnt=vcnt=0 and first tick on the second clock.
- Upstream may change pix_rgb/pix_sof only after a handshake or while pix_valid=0.

Test Plan:
- Release reset, pix_valid=0 for 2 frames -> hsync low 96 ticks per 800 at hcnt 656; vsync low for lines 490-491; frame length 840000 clocks; rgb=0; underflow never pulses (SEEK).
- Stream a full frame, first pixel sof=1 with rgb=3'b100, rest rgb=3'b010 -> vga_r=1 on first visible pixel one clock after the (0,0) tick; exactly 307200 handshakes per frame; no handshakes during blanking.
- Same as the previous scenario, but drop pix_valid for the 5 pixels at (100..104, 20) -> black at those 5 slots; 5 underflow pulses; stream continues aligned at (105, 20).
- In SEEK, present 7 non-sof pixels and then an sof pixel -> the 7 are discarded (7 handshakes), sof held with ready=0 until the (0,0) tick, then accepted.
- Mid-frame sof at (320,200) -> no handshake; black from that slot onward; WAIT_FRAME; the sof pixel is displayed at (0,0) of the next frame.
- Assert reset at (400,300) for 3 clocks -> outputs hsync=vsync=1, rgb=0 immediately; after release, counters restart at 0 and state is SEEK.
